// File: rtl/nn_weight_update.sv
// Stochastic-computing weight update: accumulates signed delta*act over a window, then
// applies a learning-rate-scaled step to a sign-magnitude weight. Macro NN_WUPDATE_EXTRND_EN
// replaces the internal LFSR with an external RND input.
module nn_weight_update #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EPOCH_LOG2 = 8,
  parameter int unsigned LR_SHIFT   = 2,
  parameter int unsigned W_INIT     = 128,
  parameter int unsigned SEED       = 1
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             delta,
  input  logic             SIGN,
  input  logic             act,
`ifdef NN_WUPDATE_EXTRND_EN
  input  logic [WIDTH-1:0] RND,
`endif
  output logic             alpha,
  output logic             W_SIGN,
  output logic [WIDTH-1:0] W,
  output logic             UPDATE
);

  localparam int unsigned AW = EPOCH_LOG2 + 2;
  // Wide enough that |W| + |step| never overflows before saturation.
  localparam int unsigned VW = ((WIDTH > AW) ? WIDTH : AW) + 2;
  localparam logic [EPOCH_LOG2-1:0] CntLast = '1;
  localparam logic signed [VW-1:0] VMax = VW'((2 ** WIDTH) - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StApply} state_e;

  state_e                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [EPOCH_LOG2-1:0]  cnt_q, cnt_d;
  logic signed [AW-1:0]   step_q, step_d;
  logic [WIDTH-1:0]       w_q, w_d;
  logic                   w_sign_q, w_sign_d;
  logic                   update_q, update_d;
  logic                   alpha_q, alpha_d;
  logic [WIDTH-1:0]       rnd;

`ifdef NN_WUPDATE_EXTRND_EN
  assign rnd = RND;
`else
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h8020_0003;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] Taps = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] lfsr_q;

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      lfsr_q <= WIDTH'(SEED);
    end else begin
      lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & Taps)};
    end
  end

  assign rnd = lfsr_q;
`endif

  logic signed [AW-1:0] contrib, acc_sum, step_calc;
  logic [AW-1:0]        acc_mag, acc_shr;
  logic signed [VW-1:0] v_mag, v_cur, v_new, v_sat, v_abs;

  always_comb begin
    contrib = '0;
    if (delta && act) begin
      contrib = SIGN ? {AW{1'b1}} : AW'(1);
    end
    acc_sum = acc_q + contrib;
    // Divide by magnitude so the step truncates toward zero for negative sums.
    acc_mag   = acc_sum[AW-1] ? -acc_sum : acc_sum;
    acc_shr   = acc_mag >> LR_SHIFT;
    step_calc = acc_sum[AW-1] ? -signed'(acc_shr) : signed'(acc_shr);

    v_mag = {{(VW-WIDTH){1'b0}}, w_q};
    v_cur = w_sign_q ? -v_mag : v_mag;
    v_new = v_cur + {{(VW-AW){step_q[AW-1]}}, step_q};
    if (v_new > VMax) begin
      v_sat = VMax;
    end else if (v_new < -VMax) begin
      v_sat = -VMax;
    end else begin
      v_sat = v_new;
    end
    v_abs = v_sat[VW-1] ? -v_sat : v_sat;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    w_d      = w_q;
    w_sign_d = w_sign_q;
    update_d = 1'b0;
    alpha_d  = (w_q != '0) && (rnd <= w_q);
    case (state_q)
      // An enabled cycle in IDLE is counted so a paused window resumes seamlessly.
      StIdle, StAccum: begin
        if (EN) begin
          if (cnt_q == CntLast) begin
            step_d  = step_calc;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StApply;
          end else begin
            acc_d   = acc_sum;
            cnt_d   = cnt_q + 1'b1;
            state_d = StAccum;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StApply: begin
        w_d      = v_abs[WIDTH-1:0];
        w_sign_d = v_sat[VW-1];
        update_d = 1'b1;
        state_d  = EN ? StAccum : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      w_q      <= WIDTH'(W_INIT);
      w_sign_q <= 1'b0;
      update_q <= 1'b0;
      alpha_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      w_q      <= w_d;
      w_sign_q <= w_sign_d;
      update_q <= update_d;
      alpha_q  <= alpha_d;
    end
  end

  assign W      = w_q;
  assign W_SIGN = w_sign_q;
  assign UPDATE = update_q;
  assign alpha  = alpha_q;

endmodule

// File: tb/tb_nn_weight_update.sv
// Directed bench for nn_weight_update: three instances (W_INIT 100, 4, 250) share stimulus.
module tb_nn_weight_update;

  logic       CLK = 1'b0;
  logic       INIT = 1'b0;
  logic       EN = 1'b0;
  logic       delta = 1'b0;
  logic       SIGN = 1'b0;
  logic       act = 1'b0;
  logic [7:0] rnd = 8'd0;

  logic       a_alpha, a_ws, a_update;
  logic [7:0] a_w;
  logic       b_alpha, b_ws, b_update;
  logic [7:0] b_w;
  logic       c_alpha, c_ws, c_update;
  logic [7:0] c_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  nn_weight_update #(.WIDTH(8), .EPOCH_LOG2(4), .LR_SHIFT(1), .W_INIT(100), .SEED(1)) dut_a (
    .CLK(CLK), .INIT(INIT), .EN(EN), .delta(delta), .SIGN(SIGN), .act(act),
`ifdef NN_WUPDATE_EXTRND_EN
    .RND(rnd),
`endif
    .alpha(a_alpha), .W_SIGN(a_ws), .W(a_w), .UPDATE(a_update)
  );

  nn_weight_update #(.WIDTH(8), .EPOCH_LOG2(4), .LR_SHIFT(1), .W_INIT(4), .SEED(1)) dut_b (
    .CLK(CLK), .INIT(INIT), .EN(EN), .delta(delta), .SIGN(SIGN), .act(act),
`ifdef NN_WUPDATE_EXTRND_EN
    .RND(rnd),
`endif
    .alpha(b_alpha), .W_SIGN(b_ws), .W(b_w), .UPDATE(b_update)
  );

  nn_weight_update #(.WIDTH(8), .EPOCH_LOG2(4), .LR_SHIFT(1), .W_INIT(250), .SEED(1)) dut_c (
    .CLK(CLK), .INIT(INIT), .EN(EN), .delta(delta), .SIGN(SIGN), .act(act),
`ifdef NN_WUPDATE_EXTRND_EN
    .RND(rnd),
`endif
    .alpha(c_alpha), .W_SIGN(c_ws), .W(c_w), .UPDATE(c_update)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    INIT = 1'b1; EN = 1'b0; delta = 1'b0; act = 1'b0; SIGN = 1'b0;
    tick();
    INIT = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    INIT = 1'b1;
    #1;
    n_checks++; if (a_w !== 8'd100) begin n_fail++; $display("FAIL reset_w got %0d exp 100", a_w); end
    n_checks++; if (b_w !== 8'd4) begin n_fail++; $display("FAIL reset_w_b got %0d exp 4", b_w); end
    n_checks++; if (c_w !== 8'd250) begin n_fail++; $display("FAIL reset_w_c got %0d exp 250", c_w); end
    n_checks++; if (a_ws !== 1'b0) begin n_fail++; $display("FAIL reset_sign got %b exp 0", a_ws); end
    n_checks++; if (a_alpha !== 1'b0) begin n_fail++; $display("FAIL reset_alpha got %b exp 0", a_alpha); end
    n_checks++; if (a_update !== 1'b0) begin n_fail++; $display("FAIL reset_update got %b exp 0", a_update); end
    tick();
    tick();
    INIT = 1'b0;
    tick();
    n_checks++; if (a_update !== 1'b0) begin n_fail++; $display("FAIL reset_release_update got %b exp 0", a_update); end
  endtask

  task automatic test_density();
    int ca, cb, cc;
    ca = 0; cb = 0; cc = 0;
    EN = 1'b0;
    tick();
    tick();
`ifdef NN_WUPDATE_EXTRND_EN
    for (int i = 1; i <= 255; i++) begin
      rnd = 8'(i);
      tick();
      ca += int'(a_alpha); cb += int'(b_alpha); cc += int'(c_alpha);
    end
    rnd = 8'd0;
`else
    // Full LFSR period visits every nonzero value once, so the count equals W.
    for (int i = 0; i < 255; i++) begin
      tick();
      ca += int'(a_alpha); cb += int'(b_alpha); cc += int'(c_alpha);
    end
`endif
    n_checks++; if (ca != 100) begin n_fail++; $display("FAIL density_w100 got %0d exp 100", ca); end
    n_checks++; if (cb != 4) begin n_fail++; $display("FAIL density_w4 got %0d exp 4", cb); end
    n_checks++; if (cc != 250) begin n_fail++; $display("FAIL density_w250 got %0d exp 250", cc); end
  endtask

  task automatic test_positive_window();
    int upd;
    upd = 0;
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      upd += int'(a_update);
    end
    n_checks++; if (upd != 0) begin n_fail++; $display("FAIL pos_early_update got %0d exp 0", upd); end
    n_checks++; if (a_w !== 8'd100) begin n_fail++; $display("FAIL pos_w_before got %0d exp 100", a_w); end
    EN = 1'b0;
    tick();
    n_checks++; if (a_w !== 8'd108) begin n_fail++; $display("FAIL pos_w got %0d exp 108", a_w); end
    n_checks++; if (a_update !== 1'b1) begin n_fail++; $display("FAIL pos_update got %b exp 1", a_update); end
    n_checks++; if (a_ws !== 1'b0) begin n_fail++; $display("FAIL pos_sign got %b exp 0", a_ws); end
    n_checks++; if (c_w !== 8'd255) begin n_fail++; $display("FAIL pos_c_sat got %0d exp 255", c_w); end
    tick();
    n_checks++; if (a_update !== 1'b0) begin n_fail++; $display("FAIL pos_update_width got %b exp 0", a_update); end
    n_checks++; if (a_w !== 8'd108) begin n_fail++; $display("FAIL pos_w_hold got %0d exp 108", a_w); end
  endtask

  task automatic test_reset_in_apply();
    int upd;
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    EN = 1'b0;
    #2;
    INIT = 1'b1;
    #1;
    n_checks++; if (a_w !== 8'd100) begin n_fail++; $display("FAIL async_w got %0d exp 100", a_w); end
    n_checks++; if (a_update !== 1'b0) begin n_fail++; $display("FAIL async_update got %b exp 0", a_update); end
    n_checks++; if (a_alpha !== 1'b0) begin n_fail++; $display("FAIL async_alpha got %b exp 0", a_alpha); end
    tick();
    tick();
    INIT = 1'b0;
    upd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      upd += int'(a_update);
    end
    n_checks++; if (upd != 0) begin n_fail++; $display("FAIL apply_discard got %0d pulses exp 0", upd); end
    n_checks++; if (a_w !== 8'd100) begin n_fail++; $display("FAIL apply_discard_w got %0d exp 100", a_w); end
    EN = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    INIT = 1'b1;
    #2;
    INIT = 1'b0;
    upd = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      upd += int'(a_update);
    end
    n_checks++; if (upd != 0) begin n_fail++; $display("FAIL window_discard got %0d pulses exp 0", upd); end
    n_checks++; if (a_w !== 8'd100) begin n_fail++; $display("FAIL window_discard_w got %0d exp 100", a_w); end
    EN = 1'b0;
  endtask

  task automatic test_sign_crossing();
    do_reset();
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    EN = 1'b0;
    tick();
    n_checks++; if (b_w !== 8'd4) begin n_fail++; $display("FAIL cross_w got %0d exp 4", b_w); end
    n_checks++; if (b_ws !== 1'b1) begin n_fail++; $display("FAIL cross_sign got %b exp 1", b_ws); end
    n_checks++; if (b_update !== 1'b1) begin n_fail++; $display("FAIL cross_update got %b exp 1", b_update); end
    tick();
    n_checks++; if (b_update !== 1'b0) begin n_fail++; $display("FAIL cross_update_width got %b exp 0", b_update); end
    EN = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    EN = 1'b0;
    tick();
    n_checks++; if (b_w !== 8'd12) begin n_fail++; $display("FAIL cross2_w got %0d exp 12", b_w); end
    n_checks++; if (b_ws !== 1'b1) begin n_fail++; $display("FAIL cross2_sign got %b exp 1", b_ws); end
  endtask

  task automatic test_saturation_pause();
    int upd;
    do_reset();
    upd = 0;
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); upd += int'(c_update); end
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); upd += int'(c_update); end
    EN = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); upd += int'(c_update); end
    n_checks++; if (upd != 0) begin n_fail++; $display("FAIL pause_early_update got %0d exp 0", upd); end
    n_checks++; if (c_w !== 8'd250) begin n_fail++; $display("FAIL pause_w_before got %0d exp 250", c_w); end
    EN = 1'b0;
    tick();
    n_checks++; if (c_w !== 8'd255) begin n_fail++; $display("FAIL sat_w got %0d exp 255", c_w); end
    n_checks++; if (c_ws !== 1'b0) begin n_fail++; $display("FAIL sat_sign got %b exp 0", c_ws); end
    n_checks++; if (c_update !== 1'b1) begin n_fail++; $display("FAIL sat_update got %b exp 1", c_update); end
  endtask

  task automatic test_truncation();
    do_reset();
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    act = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    EN = 1'b0;
    tick();
    n_checks++; if (a_w !== 8'd99) begin n_fail++; $display("FAIL trunc_w got %0d exp 99", a_w); end
    n_checks++; if (a_ws !== 1'b0) begin n_fail++; $display("FAIL trunc_sign got %b exp 0", a_ws); end
  endtask

  task automatic test_zero_weight();
    int cb;
    do_reset();
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    act = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    EN = 1'b0;
    tick();
    n_checks++; if (b_w !== 8'd0) begin n_fail++; $display("FAIL zero_w got %0d exp 0", b_w); end
    n_checks++; if (b_ws !== 1'b0) begin n_fail++; $display("FAIL zero_sign got %b exp 0", b_ws); end
    n_checks++; if (b_update !== 1'b1) begin n_fail++; $display("FAIL zero_update got %b exp 1", b_update); end
    cb = 0;
    rnd = 8'd0;
`ifdef NN_WUPDATE_EXTRND_EN
    for (int i = 0; i < 8; i++) begin tick(); cb += int'(b_alpha); end
`else
    for (int i = 0; i < 255; i++) begin tick(); cb += int'(b_alpha); end
`endif
    n_checks++; if (cb != 0) begin n_fail++; $display("FAIL zero_alpha got %0d exp 0", cb); end
  endtask

  task automatic test_back_to_back();
    int upd;
    do_reset();
    upd = 0;
    EN = 1'b1; delta = 1'b1; act = 1'b1; SIGN = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      upd += int'(a_update);
      if (k == 17) begin
        n_checks++; if (a_w !== 8'd108 || a_update !== 1'b1) begin
          n_fail++; $display("FAIL b2b_first got w=%0d upd=%b exp w=108 upd=1", a_w, a_update);
        end
      end
      if (k == 33) begin
        n_checks++; if (a_w !== 8'd108) begin n_fail++; $display("FAIL b2b_hold got %0d exp 108", a_w); end
      end
    end
    n_checks++; if (a_w !== 8'd116 || a_update !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got w=%0d upd=%b exp w=116 upd=1", a_w, a_update);
    end
    n_checks++; if (upd != 2) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 2", upd); end
    EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_density();
    test_positive_window();
    test_reset_in_apply();
    test_sign_crossing();
    test_saturation_pause();
    test_truncation();
    test_zero_weight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
